pueo_multibeam_trigger: RTL and testbench

Parametrised successor to the dual-beam power trigger. It accepts NBEAMS beamformed sample blocks per clock and computes each beam's coherent power per clock. Each beam's power is compared against its own double-buffered threshold, and the block emits one registered trigger bit per beam. Each beam also has a programmable holdoff and a mask. It sits between the beamformer output and the trigger-combining logic.

---
 rtl/pueo_multibeam_trigger.sv | 134 +++++++++++++
 tb/tb_pueo_multibeam_trigger.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pueo_multibeam_trigger.sv
// Per-beam coherent power trigger: offset convert, channel sum, square, sample sum, compare/holdoff.
// Fixed 4-edge data latency to trigger_o, one block per clock per beam, never stalls.
module pueo_multibeam_trigger #(
  parameter int NBEAMS  = 4,
  parameter int NCHAN   = 8,
  parameter int NSAMP   = 8,
  parameter int NBITS   = 5,
  parameter int TBITS   = 18,
  parameter int HOLDOFF = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NBEAMS*NCHAN*NSAMP*NBITS-1:0]  beam_i,
  input  logic [TBITS-1:0]                     thresh_i,
  input  logic [(NBEAMS > 1 ? $clog2(NBEAMS) : 1)-1:0] thresh_addr_i,
  input  logic                                 thresh_wr_i,
  input  logic                                 update_i,
  input  logic [NBEAMS-1:0]                    mask_i,
  output logic [NBEAMS-1:0]                    trigger_o
);

  localparam int SW = NBITS + $clog2(NCHAN);
  localparam int QW = 2 * SW;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic        [NBITS-1:0] raw      [NBEAMS][NCHAN][NSAMP];
  logic signed [NBITS-1:0] x_q      [NBEAMS][NCHAN][NSAMP];
  logic signed [SW-1:0]    s_d      [NBEAMS][NSAMP];
  logic signed [SW-1:0]    s_q      [NBEAMS][NSAMP];
  logic signed [QW-1:0]    sq_d     [NBEAMS][NSAMP];
  logic        [QW-1:0]    q_q      [NBEAMS][NSAMP];
  logic        [TBITS-1:0] p_d      [NBEAMS];
  logic        [TBITS-1:0] p_q      [NBEAMS];
  logic        [TBITS-1:0] shadow_q [NBEAMS];
  logic        [TBITS-1:0] active_q [NBEAMS];
  logic        [HW-1:0]    hold_q   [NBEAMS];
  logic        [3:0]       pipe_valid;
  logic        [NBEAMS-1:0] trig_d;

  always_comb begin
    for (int b = 0; b < NBEAMS; b++)
      for (int c = 0; c < NCHAN; c++)
        for (int s = 0; s < NSAMP; s++)
          raw[b][c][s] = beam_i[NBITS*(NSAMP*(NCHAN*b+c)+s) +: NBITS];
  end

  // Stage 1: offset binary to two's complement is an MSB flip.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBEAMS; b++)
      for (int c = 0; c < NCHAN; c++)
        for (int s = 0; s < NSAMP; s++)
          if (rst_i) x_q[b][c][s] <= '0;
          else       x_q[b][c][s] <= {~raw[b][c][s][NBITS-1], raw[b][c][s][NBITS-2:0]};
  end

  always_comb begin
    for (int b = 0; b < NBEAMS; b++)
      for (int s = 0; s < NSAMP; s++) begin
        s_d[b][s] = '0;
        for (int c = 0; c < NCHAN; c++)
          s_d[b][s] = s_d[b][s] + SW'(x_q[b][c][s]);
      end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBEAMS; b++)
      for (int s = 0; s < NSAMP; s++)
        if (rst_i) s_q[b][s] <= '0;
        else       s_q[b][s] <= s_d[b][s];
  end

  always_comb begin
    for (int b = 0; b < NBEAMS; b++)
      for (int s = 0; s < NSAMP; s++)
        sq_d[b][s] = QW'(s_q[b][s]) * QW'(s_q[b][s]);
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBEAMS; b++)
      for (int s = 0; s < NSAMP; s++)
        if (rst_i) q_q[b][s] <= '0;
        else       q_q[b][s] <= sq_d[b][s];
  end

  always_comb begin
    for (int b = 0; b < NBEAMS; b++) begin
      p_d[b] = '0;
      for (int s = 0; s < NSAMP; s++)
        p_d[b] = p_d[b] + TBITS'(q_q[b][s]);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBEAMS; b++)
      if (rst_i) p_q[b] <= '0;
      else       p_q[b] <= p_d[b];
  end

  // Update copies the pre-write shadow, so a same-cycle write only lands in shadow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        shadow_q[b] <= '1;
        active_q[b] <= '1;
      end
    end else begin
      if (update_i)
        for (int b = 0; b < NBEAMS; b++) active_q[b] <= shadow_q[b];
      if (thresh_wr_i && (int'(thresh_addr_i) < NBEAMS))
        shadow_q[thresh_addr_i] <= thresh_i;
    end
  end

  always_comb begin
    for (int b = 0; b < NBEAMS; b++)
      trig_d[b] = (p_q[b] > active_q[b]) & ~mask_i[b] & (hold_q[b] == '0) & pipe_valid[3];
  end

  // Stage 5: a masked beam cannot fire, so it never reloads its holdoff.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trigger_o  <= '0;
      pipe_valid <= '0;
      for (int b = 0; b < NBEAMS; b++) hold_q[b] <= '0;
    end else begin
      trigger_o  <= trig_d;
      pipe_valid <= {pipe_valid[2:0], 1'b1};
      for (int b = 0; b < NBEAMS; b++)
        if (trig_d[b])             hold_q[b] <= HW'(HOLDOFF);
        else if (hold_q[b] != '0)  hold_q[b] <= hold_q[b] - HW'(1);
    end
  end

endmodule

// File: tb/tb_pueo_multibeam_trigger.sv
// Directed bench for pueo_multibeam_trigger at default parameters.
module tb_pueo_multibeam_trigger;

  localparam int NB = 4, NC = 8, NS = 8, NBT = 5, TB = 18;
  localparam int BW = NB*NC*NS*NBT;
  localparam logic [TB-1:0] ONES = '1;

  logic          clk;
  logic          rst_i;
  logic [BW-1:0] beam_i;
  logic [TB-1:0] thresh_i;
  logic [1:0]    thresh_addr_i;
  logic          thresh_wr_i;
  logic          update_i;
  logic [NB-1:0] mask_i;
  logic [NB-1:0] trigger_o;

  int checks = 0;
  int failures = 0;

  pueo_multibeam_trigger dut (
    .clk_i(clk), .rst_i(rst_i), .beam_i(beam_i), .thresh_i(thresh_i),
    .thresh_addr_i(thresh_addr_i), .thresh_wr_i(thresh_wr_i), .update_i(update_i),
    .mask_i(mask_i), .trigger_o(trigger_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            lo [NB];
    int            hi [NB];
    int            th [NB];
    logic [NB-1:0] exp_trig;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Samples 0..NS/2-1 of each beam take lo[b], the rest hi[b], identical on every channel.
  function automatic logic [BW-1:0] mk(input int lo [NB], input int hi [NB]);
    logic [BW-1:0] r;
    logic [NBT-1:0] v;
    r = '0;
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NC; c++)
        for (int s = 0; s < NS; s++) begin
          v = (s < NS/2) ? NBT'(lo[b]) : NBT'(hi[b]);
          r[NBT*(NS*(NC*b+c)+s) +: NBT] = v;
        end
    return r;
  endfunction

  function automatic logic [BW-1:0] mk_all(input int v);
    int a [NB];
    for (int b = 0; b < NB; b++) a[b] = v;
    return mk(a, a);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wr_th(input logic [1:0] a, input logic [TB-1:0] v);
    thresh_addr_i = a;
    thresh_i      = v;
    thresh_wr_i   = 1'b1;
    tick();
    thresh_wr_i   = 1'b0;
  endtask

  task automatic upd();
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] e;
    bit found;

    vt[0] = '{name:"zero_power", lo:'{16,16,16,16}, hi:'{16,16,16,16}, th:'{0,0,0,0},                   exp_trig:4'b0000};
    vt[1] = '{name:"full_scale", lo:'{31,31,31,31}, hi:'{31,31,31,31}, th:'{115199,115200,0,115200},    exp_trig:4'b0101};
    vt[2] = '{name:"neg_extreme", lo:'{0,0,0,0},     hi:'{0,0,0,0},     th:'{131071,131072,131071,0},    exp_trig:4'b1101};
    vt[3] = '{name:"half_block", lo:'{15,15,15,15}, hi:'{16,16,16,16}, th:'{255,256,0,1000},            exp_trig:4'b0101};
    vt[4] = '{name:"mixed_beams", lo:'{31,16,0,15},  hi:'{31,16,0,16},  th:'{0,0,115200,255},            exp_trig:4'b1101};

    rst_i = 1'b1; beam_i = mk_all(16); thresh_i = '0; thresh_addr_i = '0;
    thresh_wr_i = 1'b0; update_i = 1'b0; mask_i = '0;
    @(negedge clk);
    tick();
    rst_i = 1'b0;
    chk("reset_state", trigger_o, 4'b0000);

    // Table: data applied at edge n must show up after edge n+4, not n+3.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      beam_i = mk_all(16);
      for (int b = 0; b < NB; b++) wr_th(2'(b), TB'(vt[i].th[b]));
      upd();
      beam_i = mk(vt[i].lo, vt[i].hi);
      repeat (4) tick();
      chk({vt[i].name, "_early"}, trigger_o, 4'b0000);
      tick();
      chk(vt[i].name, trigger_o, vt[i].exp_trig);
    end

    // Holdoff pattern, then mask on beam 2, then unmask.
    do_reset();
    beam_i = mk_all(16);
    for (int b = 0; b < NB; b++) wr_th(2'(b), '0);
    upd();
    beam_i = mk_all(31);
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("holdoff", trigger_o, (k % 5 == 0) ? 4'b1111 : 4'b0000);
    end
    mask_i = 4'b0100;
    for (int k = 10; k < 16; k++) begin
      tick();
      chk("masked", trigger_o, (k % 5 == 0) ? 4'b1011 : 4'b0000);
    end
    mask_i = 4'b0000;
    for (int k = 16; k < 22; k++) begin
      tick();
      e = (k == 16 || k == 21) ? 4'b0100 : (k == 20) ? 4'b1011 : 4'b0000;
      chk("unmasked", trigger_o, e);
    end

    // Double buffering.
    do_reset();
    beam_i = mk_all(31);
    wr_th(2'd0, '0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("shadow_only", trigger_o, 4'b0000);
    end
    upd();
    chk("update_edge", trigger_o, 4'b0000);
    tick();
    chk("update_next", trigger_o, 4'b0001);
    wr_th(2'd1, '0);
    thresh_addr_i = 2'd1; thresh_i = ONES; thresh_wr_i = 1'b1; update_i = 1'b1;
    tick();
    thresh_wr_i = 1'b0; update_i = 1'b0;
    tick();
    chk("wr_upd_old_value", {3'b000, trigger_o[1]}, 4'b0001);
    upd();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("second_update", {3'b000, trigger_o[1]}, 4'b0000);
    end

    // Reset mid-stream, aligned so an unreset design would fire at the reset edge.
    do_reset();
    beam_i = mk_all(16);
    for (int b = 0; b < NB; b++) wr_th(2'(b), '0);
    upd();
    beam_i = mk_all(31);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (trigger_o[0]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL stream_start actual=no_trigger required=trigger within 20 cycles");
    end
    repeat (4) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_edge", trigger_o, 4'b0000);
    wr_th(2'd0, '0);
    chk("rst_blank1", trigger_o, 4'b0000);
    upd();
    chk("rst_blank2", trigger_o, 4'b0000);
    tick();
    chk("rst_blank3", trigger_o, 4'b0000);
    tick();
    chk("rst_blank4", trigger_o, 4'b0000);
    tick();
    chk("rst_resume", trigger_o, 4'b0001);

    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("rst_no_resume", trigger_o, 4'b0000);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
